// File: rtl/aes_key_expander.sv
// AES key schedule generator: streams round keys 0..Nr for 128/192/256-bit keys,
// one expanded word per cycle, with a valid/ready round-key output register.

module aes_sbox (
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign dout_o = SBOX[din_i];
endmodule

module aes_key_expander #(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key_in,
  output logic                  busy,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [127:0]          rk_data,
  output logic [3:0]            rk_idx,
  output logic                  rk_last,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t        state_q, state_d;
  logic          busy_q, busy_d, err_q, err_d;
  logic          rk_valid_q, rk_valid_d, rk_last_q, rk_last_d;
  logic [3:0]    rk_idx_q, rk_idx_d;
  logic [127:0]  rk_data_q, rk_data_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [5:0]    k_q, k_d, last_k_q, last_k_d;
  logic [2:0]    mod_q, mod_d, nkm1_q, nkm1_d;
  logic [255:0]  key_q, key_d, key_pad;
  logic [31:0]   win_q [8];
  logic [31:0]   win_d [8];
  logic [31:0]   asm_q [3];
  logic [31:0]   asm_d [3];

  logic [3:0]    nk_sel;
  logic [2:0]    nkm1_sel;
  logic [5:0]    last_k_sel;
  logic          legal, from_key, complete, stall, produce, accept;
  logic [31:0]   wprev, wnk, sb_in, sb_out, temp, w_new, key_word;

  assign key_pad = 256'(key_in);

  always_comb begin
    nk_sel     = 4'd8;
    nkm1_sel   = 3'd7;
    last_k_sel = 6'd59;
    case (key_len)
      2'd0: begin nk_sel = 4'd4; nkm1_sel = 3'd3; last_k_sel = 6'd43; end
      2'd1: begin nk_sel = 4'd6; nkm1_sel = 3'd5; last_k_sel = 6'd51; end
      default: ;
    endcase
  end

  assign legal = (key_len != 2'd3) && (nk_sel <= MAX_NK_W);

  // win_q[0] is w[k-1]; win_q[Nk-1] is w[k-Nk]
  assign wprev    = win_q[0];
  assign wnk      = win_q[nkm1_q];
  assign sb_in    = (mod_q == 3'd0) ? {wprev[7:0], wprev[31:8]} : wprev;
  assign key_word = key_q[{k_q[2:0], 5'd0} +: 32];
  assign from_key = (k_q <= {3'd0, nkm1_q});

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.din_i(sb_in[g*8 +: 8]), .dout_o(sb_out[g*8 +: 8]));
  end

  always_comb begin
    if (mod_q == 3'd0)                         temp = sb_out ^ {24'h0, rcon_q};
    else if (nkm1_q == 3'd7 && mod_q == 3'd4)  temp = sb_out;
    else                                       temp = wprev;
  end

  assign w_new    = from_key ? key_word : (wnk ^ temp);
  assign complete = (k_q[1:0] == 2'd3);
  assign accept   = rk_valid_q && rk_ready;
  // A finished round may only land once the output register is free or leaving
  assign stall    = rk_valid_q && !rk_ready && complete;
  assign produce  = (state_q == RUN) && !stall;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    rk_valid_d = rk_valid_q;
    rk_last_d  = rk_last_q;
    rk_idx_d   = rk_idx_q;
    rk_data_d  = rk_data_q;
    rcon_d     = rcon_q;
    k_d        = k_q;
    mod_d      = mod_q;
    nkm1_d     = nkm1_q;
    last_k_d   = last_k_q;
    key_d      = key_q;
    win_d      = win_q;
    asm_d      = asm_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            state_d  = RUN;
            busy_d   = 1'b1;
            key_d    = key_pad;
            nkm1_d   = nkm1_sel;
            last_k_d = last_k_sel;
            k_d      = 6'd0;
            mod_d    = 3'd0;
            rcon_d   = 8'h01;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          rk_valid_d = 1'b0;
          rk_last_d  = 1'b0;
        end
        if (produce) begin
          win_d[0] = w_new;
          for (int i = 1; i < 8; i++) win_d[i] = win_q[i-1];
          k_d   = k_q + 6'd1;
          mod_d = (mod_q == nkm1_q) ? 3'd0 : mod_q + 3'd1;
          if (!from_key && mod_q == 3'd0) rcon_d = xtime(rcon_q);
          case (k_q[1:0])
            2'd0: asm_d[0] = w_new;
            2'd1: asm_d[1] = w_new;
            2'd2: asm_d[2] = w_new;
            default: begin
              rk_data_d  = {w_new, asm_q[2], asm_q[1], asm_q[0]};
              rk_idx_d   = k_q[5:2];
              rk_last_d  = (k_q == last_k_q);
              rk_valid_d = 1'b1;
            end
          endcase
          if (k_q == last_k_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept) begin
          rk_valid_d = 1'b0;
          rk_last_d  = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      rk_idx_q   <= 4'd0;
      rk_data_q  <= 128'd0;
      rcon_q     <= 8'h01;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
      rk_idx_q   <= rk_idx_d;
      rk_data_q  <= rk_data_d;
      rcon_q     <= rcon_d;
    end
  end

  // Working datapath is reloaded on every accepted start, so it needs no reset
  always_ff @(posedge clk) begin
    k_q      <= k_d;
    mod_q    <= mod_d;
    nkm1_q   <= nkm1_d;
    last_k_q <= last_k_d;
    key_q    <= key_d;
    win_q    <= win_d;
    asm_q    <= asm_d;
  end

  assign busy     = busy_q;
  assign err      = err_q;
  assign rk_valid = rk_valid_q;
  assign rk_last  = rk_last_q;
  assign rk_idx   = rk_idx_q;
  assign rk_data  = rk_data_q;
endmodule

// File: doc/aes_key_expander.md
AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, meaning the largest key length in 32-bit words supported (legal values 4, 6, 8).
REQ-002 SHALL have clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have start  input  1  request to begin an expansion, sampled only in IDLE.
REQ-005 SHALL have key_len  input  2  key length: 0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=illegal.
REQ-006 SHALL have key_in  input  32*MAX_NK  cipher key; word w[k] at [k*32+:32], byte 0 of each word at [7:0]; sampled on start accept.
REQ-007 SHALL have busy  output  1  high from start accept until the final round key is accepted.
REQ-008 SHALL have rk_valid  output  1  round key available.
REQ-009 SHALL have rk_ready  input  1  consumer accepts round key when rk_valid and rk_ready are high on a rising edge.
REQ-010 SHALL have rk_data  output  128  round key r = {w[4r+3], w[4r+2], w[4r+1], w[4r]}, using the same word and byte layout as key_in.
REQ-011 SHALL have rk_idx  output  4  round index r of rk_data, 0..Nr.
REQ-012 SHALL have rk_last  output  1  high with rk_valid when r = Nr.
REQ-013 SHALL have err  output  1  one-cycle pulse on a rejected start.

Function
REQ-014 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on a legal start; RUN->DRAIN when word 4(Nr+1)-1 is produced; DRAIN->IDLE when the final round key is accepted.
REQ-015 start with key_len=3, or with Nk > MAX_NK, SHALL pulse err in the next cycle and stay in IDLE with no key output.
REQ-016 start while busy SHALL be ignored, with no err.
REQ-017 RUN SHALL produce exactly one 32-bit word per non-stalled cycle, in order w[0], w[1], ...: words k < Nk are copied from key_in; words k >= Nk are w[k-Nk] XOR temp.
REQ-018 temp SHALL be SubWord(RotWord(w[k-1])) XOR {24'h0, rcon} when k mod Nk = 0; SubWord(w[k-1]) when Nk=8 and k mod 8 = 4; otherwise w[k-1].
REQ-019 RotWord SHALL move byte 1->0, 2->1, 3->2, 0->3; rcon SHALL be XORed into byte 0 ([7:0]).
REQ-020 rcon SHALL start at 8'h01 and advance by GF(2^8) xtime (shift left, XOR 8'h1b on carry) after each use: 01,02,04,08,10,20,40,80,1b,36.
REQ-021 SubWord SHALL use four parallel instances of the codebase aes_sbox; the last Nk words SHALL be held in an 8-entry sliding window.
REQ-022 Words SHALL collect in a 4-word assembly buffer; the 4th word of each round SHALL be written directly to the output register at the same edge.
REQ-023 With no back-pressure, rk_valid for round r SHALL first be high after rising edge 4(r+1) counted from the start-accept edge, giving 44/52/60 cycles to the last key.
REQ-024 When the output register holds an unaccepted key and the next word would complete a round, word production SHALL stall with all state frozen.
REQ-025 When a key is accepted and a new one completes on the same edge, the output register SHALL load the new key and rk_valid SHALL stay high.
REQ-026 rk_data, rk_idx and rk_last SHALL be stable while rk_valid=1 and rk_ready=0.
REQ-027 rk_valid SHALL deassert after the last key is accepted; busy SHALL fall on that same edge.

Reset
REQ-028 rst SHALL immediately clear busy, rk_valid, rk_last, err, rk_idx and rk_data to 0, set state to IDLE and rcon to 8'h01, including mid-expansion.
REQ-029 After rst deasserts, the first legal start SHALL behave identically to one issued from power-up.

Verification
REQ-030 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c (byte0 first), rk_ready=1 -> w[4]=a0fafe17, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last, valid after edge 44.
REQ-031 AES-192 key 000102..1617 -> round 12 = a4970a331a78dc09c418c271e3a41d5d, rk_idx=12, rk_last=1.
REQ-032 AES-256 key 000102..1e1f, rk_ready toggling randomly -> 15 keys in order, round 14 = 24fc79ccbf0979e9371ac23c6d68de36, outputs stable while stalled.
REQ-033 start with key_len=3, then start while busy -> single err pulse, no rk_valid; the second start is ignored and does not corrupt the run.
REQ-034 rst asserted at round 5 of an AES-256 run, then an AES-128 start -> outputs 0 during reset, then correct AES-128 sequence beginning with rcon 8'h01.
